// File: rtl/sonar_filter_core.sv
// Echo-width to millimetre converter with a moving-average window and threshold alarm,
// exposed through the standard MMIO slot interface.
module sonar_filter_core #(
  parameter int DIV_MM   = 583,
  parameter int AVG_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic [31:0] meas_data,
  input  logic        meas_valid,
  output logic        alarm
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam logic [AVG_LOG2:0] FILL_FULL = {1'b1, {AVG_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, ACC} state_t;
  state_t state, state_next;

  logic [31:0] dvd, rem, quo, rem_nx;
  logic [32:0] rem_sh, rem_sub;
  logic        q_bit;
  logic [4:0]  iter;

  logic [31:0] last_mm, sum, avg_mm;
  logic [31:0] win [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [AVG_LOG2:0]   fill;
  logic [15:0] thr_mm;
  logic        new_flag, err, overrun, avg_valid, busy;

  logic wr_en, st_clr, thr_we, filt_clr, accept, timeout;

  assign wr_en    = cs && write;
  assign st_clr   = wr_en && (addr[2:0] == 3'd2) && wr_data[0];
  assign thr_we   = wr_en && (addr[2:0] == 3'd3);
  assign filt_clr = wr_en && (addr[2:0] == 3'd4) && wr_data[0];
  assign accept   = (state == IDLE) && meas_valid && (meas_data != '1);
  assign timeout  = (state == IDLE) && meas_valid && (meas_data == '1);

  assign busy      = (state != IDLE);
  assign avg_mm    = sum >> AVG_LOG2;
  assign avg_valid = (fill == FILL_FULL);

  // Restoring divider step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh  = {rem, dvd[31]};
    rem_sub = rem_sh - 33'(DIV_MM);
    q_bit   = (rem_sh >= 33'(DIV_MM));
    rem_nx  = q_bit ? rem_sub[31:0] : rem_sh[31:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = DIV;
      DIV:     if (iter == 5'd31) state_next = ACC;
      ACC:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      dvd      <= '0;
      rem      <= '0;
      quo      <= '0;
      iter     <= '0;
      last_mm  <= '0;
      sum      <= '0;
      wr_ptr   <= '0;
      fill     <= '0;
      thr_mm   <= '0;
      new_flag <= 1'b0;
      err      <= 1'b0;
      overrun  <= 1'b0;
      alarm    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) win[i] <= '0;
    end else begin
      state <= state_next;
      alarm <= avg_valid && (thr_mm != '0) && (avg_mm < {16'b0, thr_mm});

      if (accept) begin
        dvd  <= meas_data;
        rem  <= '0;
        quo  <= '0;
        iter <= '0;
      end else if (state == DIV) begin
        dvd  <= dvd << 1;
        rem  <= rem_nx;
        quo  <= {quo[30:0], q_bit};
        iter <= iter + 5'd1;
      end

      if (state == ACC) last_mm <= quo;

      // A filter clear in the ACC cycle wins over the window update.
      if (filt_clr) begin
        sum    <= '0;
        wr_ptr <= '0;
        fill   <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) win[i] <= '0;
      end else if (state == ACC) begin
        win[wr_ptr] <= quo;
        sum         <= sum - win[wr_ptr] + quo;
        wr_ptr      <= wr_ptr + AVG_LOG2'(1);
        if (fill != FILL_FULL) fill <= fill + (AVG_LOG2+1)'(1);
      end

      if (thr_we) thr_mm <= wr_data[15:0];

      // Sets are assigned after the status clear so they take priority.
      if (st_clr) begin
        new_flag <= 1'b0;
        err      <= 1'b0;
        overrun  <= 1'b0;
      end
      if (state == ACC) new_flag <= 1'b1;
      if (timeout) err <= 1'b1;
      if (meas_valid && busy) overrun <= 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr[2:0])
      3'd0:    rd_data = last_mm;
      3'd1:    rd_data = avg_mm;
      3'd2:    rd_data = {26'b0, overrun, busy, err, alarm, avg_valid, new_flag};
      3'd3:    rd_data = {16'b0, thr_mm};
      default: rd_data = '0;
    endcase
  end

  logic unused;
  assign unused = ^{read, addr[4:3], wr_data[31:16], rem_sub[32]};

endmodule

// File: tb/tb_sonar_filter_core.sv
// Directed self-checking bench for sonar_filter_core.
module tb_sonar_filter_core;

  logic        clk = 1'b0;
  logic        reset, cs, read, write, meas_valid, alarm;
  logic [4:0]  addr;
  logic [31:0] wr_data, rd_data, meas_data;

  int checks   = 0;
  int failures = 0;

  always #50 clk = ~clk;

  sonar_filter_core #(.DIV_MM(583), .AVG_LOG2(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .read      (read),
    .write     (write),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .meas_data (meas_data),
    .meas_valid(meas_valid),
    .alarm     (alarm)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    addr = {2'b00, a};
    cs   = 1'b1;
    read = 1'b1;
    #1;
    d    = rd_data;
    cs   = 1'b0;
    read = 1'b0;
    check(tag, d, exp);
  endtask

  task automatic wreg(input logic [2:0] a, input logic [31:0] d);
    addr    = {2'b00, a};
    wr_data = d;
    cs      = 1'b1;
    write   = 1'b1;
    tick(1);
    cs      = 1'b0;
    write   = 1'b0;
    wr_data = '0;
  endtask

  task automatic send(input logic [31:0] d);
    meas_data  = d;
    meas_valid = 1'b1;
    tick(1);
    meas_valid = 1'b0;
    meas_data  = '0;
  endtask

  task automatic sample(input int unsigned ticks);
    send(ticks);
    tick(33);
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
    addr = '0; wr_data = '0; meas_data = '0; meas_valid = 1'b0;
    tick(2);
    reset = 1'b0;

    chk_reg("rst_last", 3'd0, 0);
    chk_reg("rst_avg", 3'd1, 0);
    chk_reg("rst_status", 3'd2, 0);
    chk_reg("rst_thr", 3'd3, 0);
    chk_reg("rst_reg4", 3'd4, 0);
    check("rst_alarm", {31'b0, alarm}, 0);

    wreg(3'd3, 32'hABCD1234);
    chk_reg("thr_upper_zero", 3'd3, 32'h0000_1234);
    wreg(3'd3, 0);
    wreg(3'd5, 32'hFFFF_FFFF);
    chk_reg("reg5_ignored", 3'd5, 0);

    // 58300 ticks -> 100 mm
    send(58300);
    chk_reg("busy_t1", 3'd2, 32'd16);
    tick(32);
    chk_reg("busy_t33", 3'd2, 32'd16);
    chk_reg("last_t33_old", 3'd0, 0);
    tick(1);
    chk_reg("last_100", 3'd0, 100);
    chk_reg("new_set", 3'd2, 32'd1);
    chk_reg("avg_first", 3'd1, 25);

    sample(582);
    chk_reg("trunc_zero", 3'd0, 0);

    wreg(3'd4, 1);
    chk_reg("clr_avg", 3'd1, 0);
    wreg(3'd2, 1);
    chk_reg("new_cleared", 3'd2, 0);
    wreg(3'd3, 300);

    sample(100 * 583);
    chk_reg("avg_s1", 3'd1, 25);
    chk_reg("stat_s1", 3'd2, 32'd1);
    sample(200 * 583);
    chk_reg("avg_s2", 3'd1, 75);
    sample(300 * 583 + 582);
    chk_reg("last_s3", 3'd0, 300);
    chk_reg("avg_s3", 3'd1, 150);
    chk_reg("stat_s3", 3'd2, 32'd1);
    check("alarm_not_valid", {31'b0, alarm}, 0);
    sample(400 * 583);
    chk_reg("avg_s4", 3'd1, 250);
    chk_reg("stat_s4", 3'd2, 32'd3);
    check("alarm_t34", {31'b0, alarm}, 0);
    tick(1);
    check("alarm_t35", {31'b0, alarm}, 1);

    wreg(3'd3, 0);
    check("alarm_lag", {31'b0, alarm}, 1);
    tick(1);
    check("alarm_thr0", {31'b0, alarm}, 0);
    wreg(3'd3, 300);
    tick(1);
    check("alarm_rearm", {31'b0, alarm}, 1);

    sample(500 * 583);
    chk_reg("avg_s5_evict", 3'd1, 350);
    tick(1);
    check("alarm_350", {31'b0, alarm}, 0);

    send(32'hFFFF_FFFF);
    chk_reg("timeout_stat", 3'd2, 32'd11);
    chk_reg("timeout_last", 3'd0, 500);
    chk_reg("timeout_avg", 3'd1, 350);

    send(700 * 583);
    tick(9);
    send(123456);
    tick(23);
    chk_reg("ovr_last", 3'd0, 700);
    chk_reg("ovr_avg", 3'd1, 475);
    chk_reg("ovr_stat", 3'd2, 32'd43);
    wreg(3'd2, 1);
    chk_reg("stat_clear", 3'd2, 32'd2);

    send(1000 * 583);
    tick(15);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_reg("mrst_last", 3'd0, 0);
    chk_reg("mrst_stat", 3'd2, 0);
    chk_reg("mrst_avg", 3'd1, 0);
    check("mrst_alarm", {31'b0, alarm}, 0);
    tick(40);
    chk_reg("mrst_no_commit", 3'd0, 0);

    sample(100 * 583);
    chk_reg("acc_pre_avg", 3'd1, 25);
    send(200 * 583);
    tick(32);
    wreg(3'd4, 1);
    chk_reg("accclr_last", 3'd0, 200);
    chk_reg("accclr_avg", 3'd1, 0);
    chk_reg("accclr_stat", 3'd2, 32'd1);
    sample(400 * 583);
    chk_reg("accclr_after", 3'd1, 100);

    wreg(3'd2, 1);
    send(100 * 583);
    tick(32);
    send(5);
    chk_reg("t33_overrun_last", 3'd0, 100);
    chk_reg("t33_overrun_stat", 3'd2, 32'd33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sonar_filter_core.md
# sonar_filter_core

MMIO slot core directly downstream of the HC-SR04 ranging core. It consumes each raw echo-width measurement in 100 MHz ticks and converts it to millimetres with a sequential divider. It keeps a moving average over the last 2^AVG_LOG2 valid samples and raises a threshold alarm. It is software-readable through the standard slot interface.

## Interface
- DIV_MM, 583: ticks per millimetre of range (100 MHz clock, round trip at 343 m/s).
- AVG_LOG2, 2: log2 of the averaging window depth (default 4 samples).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock domain, sampled on posedge clk.
- cs  in  1  slot select.
- read  in  1  slot read strobe; no side effects.
- write  in  1  slot write strobe.
- addr  in  5  register address; only addr[2:0] is decoded.
- wr_data  in  32  write data.
- rd_data  out  32  read data; combinational mux on addr[2:0].
- meas_data  in  32  raw echo width in ticks from the ranging core; 32'hFFFFFFFF is the timeout code.
- meas_valid  in  1  one-cycle strobe; meas_data is valid in the same cycle.
- alarm  out  1  registered; high while the average is below the threshold.

## Operation
- Register map (addr[2:0]):
  - 0 R: last_mm.
  - 1 R: avg_mm.
  - 2 R/W status. Read bits: [0] new, [1] avg_valid, [2] alarm, [3] err, [4] busy, [5] overrun. A write with wr_data[0]=1 clears new, err and overrun.
  - 3 R/W: thr_mm[15:0]; upper bits read 0.
  - 4 W: bit0=1 clears the filter.
  - 5–7 read 0; writes to them are ignored.
- Reset values: all registers 0, FSM in IDLE, alarm=0, buffer and sum 0, fill count 0.
- FSM states IDLE, DIV, ACC:
  - IDLE, meas_valid=1, meas_data != 32'hFFFFFFFF: latch meas_data, iteration counter = 0, go to DIV.
  - IDLE, meas_valid=1, meas_data = 32'hFFFFFFFF: set err, stay in IDLE. last_mm, buffer and new are unchanged.
  - DIV: 32-iteration restoring division of the latched ticks by DIV_MM, one quotient bit per cycle. The quotient truncates (floor); the remainder is discarded. After the 32nd iteration, go to ACC.
  - ACC, one cycle:
    - last_mm = quotient, new=1.
    - Write last_mm into buffer[wr_ptr].
    - sum = sum - old entry + last_mm. sum is 32 bits.
    - wr_ptr increments modulo 2^AVG_LOG2.
    - Fill count saturates at 2^AVG_LOG2; avg_valid=1 once it saturates.
    - Return to IDLE.
- avg_mm = sum >> AVG_LOG2, updated with sum. Before the window fills, the missing entries count as zeros.
- busy = (state != IDLE).
- meas_valid while busy: the sample is dropped and overrun is set (sticky).
- Filter clear (reg 4 bit0):
  - Zeros buffer, sum, wr_ptr, fill count, avg_valid and avg_mm in one cycle.
  - last_mm is not affected.
  - If the clear coincides with ACC, the clear wins: last_mm and new still update, but the sample does not enter the buffer.
- Status-clear write in the same cycle that ACC sets new, or an error sets err: the set wins.
- alarm_next = avg_valid && (thr_mm != 0) && (avg_mm < thr_mm). thr_mm = 0 disables the alarm.

## Timing
- meas_valid sampled in IDLE at cycle T:
  - DIV occupies T+1..T+32.
  - ACC at T+33.
  - last_mm, avg_mm and new are visible at T+34.
  - alarm is visible at T+35.
- Minimum accepted sample spacing is 34 cycles. A meas_valid at T+34 is accepted; one at T+33 or earlier is an overrun.
- A timeout sample sets err visible at T+1 and leaves busy=0.
- Register writes take effect on the next posedge. rd_data reflects the current register values in the same cycle as addr.
- reset asserted mid-DIV or mid-ACC: FSM returns to IDLE and all state returns to reset values on the next posedge. No partial result is committed.

## Test plan
- Reset, then read regs 0–4 → all 0. alarm=0, busy=0.
- meas_data=58300 at T → busy=1 at T+1..T+33, last_mm=100 and new=1 at T+34. meas_data=582 → last_mm=0 (truncation).
- Samples of 100, 200, 300, 400 mm, 34-cycle spacing → avg_valid=0 after samples 1–3 with avg_mm=25, 75, 150. After sample 4: avg_valid=1, avg_mm=250. A fifth sample of 500 mm → avg_mm=350 (oldest entry evicted).
- thr_mm=300, window average 250 → alarm=1 at T+35. Write thr_mm=0 → alarm=0 the next cycle. Window average 350 with thr_mm=300 → alarm=0.
- meas_data=32'hFFFFFFFF → err=1, last_mm and avg unchanged. Second meas_valid 10 cycles after a good sample → overrun=1, first result still correct. Status write with 1 → new, err and overrun all 0.
- reset pulse at DIV iteration 15 → IDLE, last_mm=0, busy=0 next cycle. Filter clear coinciding with ACC → last_mm updated, avg_mm=0, avg_valid=0.
